vreg_req_responder: RTL and testbench

- Responder end of the per-lane vector-register request channel.
- Accepts held read/write element requests from NUM_PORTS requesters, arbitrates them, grants them, and owns the vector register storage.
- Returns read data one cycle after grant.
- Sits between the execution unit's reg_req ports and the lane functional units.

---
 rtl/vreg_req_if.sv | 32 +++
 rtl/vreg_req_responder.sv | 134 +++++++++++++
 tb/tb_vreg_req_responder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/vreg_req_if.sv
// Vector-register request channel between requesters and the register responder.
// Each field is a packed per-port array.
interface vreg_req_if #(
    parameter int NUM_PORTS = 2,
    parameter int NUM_VREG  = 8,
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 32
);
    localparam int RP_W = $clog2(NUM_VREG);

    logic [NUM_PORTS-1:0]             req_vld;
    logic [NUM_PORTS-1:0]             req_type;
    logic [NUM_PORTS-1:0]             req_stride;
    logic [NUM_PORTS-1:0][31:0]       req_length;
    logic [NUM_PORTS-1:0][RP_W-1:0]   req_reg_ptr;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_PORTS-1:0][DATA_W-1:0] req_data;
    logic [NUM_PORTS-1:0]             req_grant;
    logic [NUM_PORTS-1:0]             rsp_vld;
    logic [NUM_PORTS-1:0][DATA_W-1:0] rsp_data;
    logic [NUM_PORTS-1:0]             rsp_err;

    modport master (
        output req_vld, req_type, req_stride, req_length, req_reg_ptr, req_addr, req_data,
        input  req_grant, rsp_vld, rsp_data, rsp_err
    );

    modport slave (
        input  req_vld, req_type, req_stride, req_length, req_reg_ptr, req_addr, req_data,
        output req_grant, rsp_vld, rsp_data, rsp_err
    );
endinterface

// File: rtl/vreg_req_responder.sv
// Responder for the per-lane vector-register request channel: owns the register
// storage, grants per-port reads freely and round-robin arbitrates a single write slot.
module vreg_req_port #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              take,
    input  logic              take_err,
    input  logic [DATA_W-1:0] take_data,
    output logic              can_take,
    output logic              grant,
    output logic              rsp_vld,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_data
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [1:0]        state;
    logic              pend_err;
    logic [DATA_W-1:0] pend_data;

    assign can_take = (state != GRANT);
    assign grant    = (state == GRANT);

    // Read data is captured at the sampling edge, so a same-edge write is not seen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            pend_err  <= 1'b0;
            pend_data <= '0;
            rsp_vld   <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
        end else begin
            case (state)
                IDLE:    if (take) state <= GRANT;
                GRANT:   state <= RESP;
                RESP:    state <= take ? GRANT : IDLE;
                default: state <= IDLE;
            endcase
            if (take) begin
                pend_err  <= take_err;
                pend_data <= take_data;
            end
            rsp_vld  <= (state == GRANT);
            rsp_err  <= (state == GRANT) && pend_err;
            rsp_data <= (state == GRANT) ? pend_data : '0;
        end
    end
endmodule

module vreg_req_responder #(
    parameter int NUM_PORTS = 2,
    parameter int NUM_VREG  = 8,
    parameter int VLEN      = 64,
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 32
) (
    input  logic       clk,
    input  logic       reset,
    vreg_req_if.slave  bus
);
    localparam int RP_W  = $clog2(NUM_VREG);
    localparam int EL_W  = $clog2(VLEN);
    localparam int MA_W  = RP_W + EL_W;
    localparam int DEPTH = NUM_VREG * VLEN;
    localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [NUM_PORTS-1:0]             can_take, oor, wr_req, take;
    logic [NUM_PORTS-1:0]             grant, rsp_vld, rsp_err;
    logic [NUM_PORTS-1:0][MA_W-1:0]   maddr;
    logic [NUM_PORTS-1:0][DATA_W-1:0] rd_data, rsp_data;
    logic [PW-1:0]                    wr_ptr, wr_sel;
    logic                             wr_any;

    assign bus.req_grant = grant;
    assign bus.rsp_vld   = rsp_vld;
    assign bus.rsp_err   = rsp_err;
    assign bus.rsp_data  = rsp_data;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        logic [63:0] idx;

        // Full 64-bit product so a large stride cannot wrap back into range.
        assign idx = bus.req_stride[g] ? 64'(bus.req_addr[g]) * 64'(bus.req_length[g])
                                       : 64'(bus.req_addr[g]);
        assign oor[g]     = (idx >= 64'(VLEN));
        assign maddr[g]   = {bus.req_reg_ptr[g], idx[EL_W-1:0]};
        assign rd_data[g] = (oor[g] || bus.req_type[g]) ? '0 : mem[maddr[g]];
        assign wr_req[g]  = bus.req_vld[g] && bus.req_type[g] && can_take[g];
        assign take[g]    = bus.req_vld[g] && can_take[g] &&
                            (!bus.req_type[g] || (wr_any && wr_sel == PW'(g)));

        vreg_req_port #(.DATA_W(DATA_W)) u_port (
            .clk       (clk),
            .reset     (reset),
            .take      (take[g]),
            .take_err  (oor[g]),
            .take_data (rd_data[g]),
            .can_take  (can_take[g]),
            .grant     (grant[g]),
            .rsp_vld   (rsp_vld[g]),
            .rsp_err   (rsp_err[g]),
            .rsp_data  (rsp_data[g])
        );
    end

    always_comb begin
        wr_any = 1'b0;
        wr_sel = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!wr_any && wr_req[(int'(wr_ptr) + k) % NUM_PORTS]) begin
                wr_any = 1'b1;
                wr_sel = PW'((int'(wr_ptr) + k) % NUM_PORTS);
            end
        end
    end

    // An out-of-range winner still moves the pointer but leaves storage alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
        end else if (wr_any) begin
            wr_ptr <= (int'(wr_sel) == NUM_PORTS - 1) ? '0 : PW'(wr_sel + 1'b1);
            if (!oor[wr_sel]) mem[maddr[wr_sel]] <= bus.req_data[wr_sel];
        end
    end
endmodule

// File: tb/tb_vreg_req_responder.sv
// Directed bench for vreg_req_responder: a vector table of single-port operations
// followed by hand-written multi-cycle sequences (conflicts, same-element, reset).
module tb_vreg_req_responder;
    localparam int NP = 2, NV = 8, VL = 64, DW = 64, AW = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    vreg_req_if #(.NUM_PORTS(NP), .NUM_VREG(NV), .DATA_W(DW), .ADDR_W(AW)) bus ();

    vreg_req_responder #(.NUM_PORTS(NP), .NUM_VREG(NV), .VLEN(VL), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          port;
        logic        typ;
        logic        str;
        logic [31:0] len;
        logic [2:0]  rp;
        logic [31:0] addr;
        logic [63:0] data;
        logic        eerr;
        logic [63:0] edata;
    } vec_t;

    int errors = 0;
    int checks = 0;
    vec_t tbl [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_all();
        bus.req_vld     = '0;
        bus.req_type    = '0;
        bus.req_stride  = '0;
        bus.req_length  = '0;
        bus.req_reg_ptr = '0;
        bus.req_addr    = '0;
        bus.req_data    = '0;
    endtask

    task automatic set_req(input int p, input logic t, input logic s, input logic [31:0] len,
                           input logic [2:0] rp, input logic [31:0] a, input logic [63:0] d);
        bus.req_vld[p]     = 1'b1;
        bus.req_type[p]    = t;
        bus.req_stride[p]  = s;
        bus.req_length[p]  = len;
        bus.req_reg_ptr[p] = rp;
        bus.req_addr[p]    = a;
        bus.req_data[p]    = d;
    endtask

    task automatic do_op(input vec_t v, input string tag);
        set_req(v.port, v.typ, v.str, v.len, v.rp, v.addr, v.data);
        step();
        chk({tag, " grant"}, 64'(bus.req_grant[v.port]), 64'd1);
        chk({tag, " early rsp"}, 64'(bus.rsp_vld[v.port]), 64'd0);
        bus.req_vld[v.port] = 1'b0;
        step();
        chk({tag, " rsp_vld"}, 64'(bus.rsp_vld[v.port]), 64'd1);
        chk({tag, " rsp_data"}, bus.rsp_data[v.port], v.edata);
        chk({tag, " rsp_err"}, 64'(bus.rsp_err[v.port]), 64'(v.eerr));
        step();
        chk({tag, " rsp one-shot"}, 64'(bus.rsp_vld[v.port]), 64'd0);
    endtask

    task automatic rd(input int p, input logic [2:0] rp, input logic [31:0] a,
                      input logic [63:0] exp, input string tag);
        vec_t v;
        v = '{p, 1'b0, 1'b0, 32'd0, rp, a, 64'd0, 1'b0, exp};
        do_op(v, tag);
    endtask

    initial begin
        //          port typ str len  rp  addr          data                   err edata
        tbl[0]  = '{0, 1'b1, 1'b0, 32'd0, 3'd2, 32'd5,         64'hDEAD_BEEF,        1'b0, 64'h0};
        tbl[1]  = '{0, 1'b0, 1'b0, 32'd0, 3'd2, 32'd5,         64'h0,                1'b0, 64'hDEAD_BEEF};
        tbl[2]  = '{1, 1'b1, 1'b0, 32'd0, 3'd0, 32'd12,        64'h77,               1'b0, 64'h0};
        tbl[3]  = '{0, 1'b0, 1'b1, 32'd4, 3'd0, 32'd3,         64'h0,                1'b0, 64'h77};
        tbl[4]  = '{1, 1'b0, 1'b0, 32'd0, 3'd0, 32'd64,        64'h0,                1'b1, 64'h0};
        tbl[5]  = '{0, 1'b1, 1'b1, 32'd4, 3'd0, 32'd20,        64'hBAD,              1'b1, 64'h0};
        tbl[6]  = '{1, 1'b0, 1'b0, 32'd0, 3'd0, 32'd12,        64'h0,                1'b0, 64'h77};
        tbl[7]  = '{0, 1'b0, 1'b0, 32'd0, 3'd0, 32'd16,        64'h0,                1'b0, 64'h0};
        tbl[8]  = '{1, 1'b1, 1'b0, 32'd0, 3'd7, 32'd63,        64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0};
        tbl[9]  = '{0, 1'b0, 1'b0, 32'd0, 3'd7, 32'd63,        64'h0,                1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[10] = '{1, 1'b0, 1'b1, 32'd2, 3'd1, 32'h8000_0000, 64'h0,                1'b1, 64'h0};
        tbl[11] = '{1, 1'b1, 1'b0, 32'd0, 3'd4, 32'd0,         64'h5,                1'b0, 64'h0};

        idle_all();
        repeat (2) step();
        chk("reset grant", 64'(bus.req_grant), 64'd0);
        chk("reset rsp_vld", 64'(bus.rsp_vld), 64'd0);
        chk("reset rsp_err", 64'(bus.rsp_err), 64'd0);
        chk("reset rsp_data0", bus.rsp_data[0], 64'd0);
        chk("reset rsp_data1", bus.rsp_data[1], 64'd0);
        reset = 1'b1;
        step();

        for (int i = 0; i < 12; i++) do_op(tbl[i], $sformatf("vec%0d", i));

        // Same element: port1 reads reg4/0 while port0 writes it.
        set_req(1, 1'b0, 1'b0, 32'd0, 3'd4, 32'd0, 64'd0);
        set_req(0, 1'b1, 1'b0, 32'd0, 3'd4, 32'd0, 64'h9);
        step();
        chk("same grants", 64'(bus.req_grant), 64'd3);
        idle_all();
        step();
        chk("same rsp_vld", 64'(bus.rsp_vld), 64'd3);
        chk("same old data", bus.rsp_data[1], 64'h5);
        chk("same wr data", bus.rsp_data[0], 64'h0);
        step();
        rd(0, 3'd4, 32'd0, 64'h9, "same new");

        // Reset during the grant cycle of a read.
        set_req(0, 1'b0, 1'b0, 32'd0, 3'd2, 32'd5, 64'd0);
        step();
        chk("rst grant", 64'(bus.req_grant[0]), 64'd1);
        reset = 1'b0;
        #1;
        chk("rst async grant", 64'(bus.req_grant), 64'd0);
        chk("rst async rsp", 64'(bus.rsp_vld), 64'd0);
        idle_all();
        step();
        chk("rst no rsp", 64'(bus.rsp_vld), 64'd0);
        chk("rst data", bus.rsp_data[0], 64'd0);
        step();
        reset = 1'b1;
        step();
        chk("rst post rsp", 64'(bus.rsp_vld), 64'd0);
        rd(0, 3'd2, 32'd5, 64'h0, "rst clr a");
        rd(1, 3'd7, 32'd63, 64'h0, "rst clr b");

        // Write conflict, pointer at 0 after reset.
        set_req(0, 1'b1, 1'b0, 32'd0, 3'd1, 32'd3, 64'h11);
        set_req(1, 1'b1, 1'b0, 32'd0, 3'd1, 32'd3, 64'h22);
        step();
        chk("cf grant1", 64'(bus.req_grant), 64'd1);
        bus.req_vld[0] = 1'b0;
        step();
        chk("cf grant2", 64'(bus.req_grant), 64'd2);
        chk("cf rsp1", 64'(bus.rsp_vld), 64'd1);
        bus.req_vld[1] = 1'b0;
        step();
        chk("cf rsp2", 64'(bus.rsp_vld), 64'd2);
        chk("cf grant idle", 64'(bus.req_grant), 64'd0);
        step();
        rd(0, 3'd1, 32'd3, 64'h22, "cf final");

        // Pointer should be back at 0: port0 wins, port1 drops before grant.
        set_req(0, 1'b1, 1'b0, 32'd0, 3'd1, 32'd3, 64'h55);
        set_req(1, 1'b1, 1'b0, 32'd0, 3'd1, 32'd3, 64'h66);
        step();
        chk("ptr grant", 64'(bus.req_grant), 64'd1);
        idle_all();
        step();
        chk("drop rsp", 64'(bus.rsp_vld), 64'd1);
        chk("drop no grant", 64'(bus.req_grant), 64'd0);
        step();
        chk("drop no rsp", 64'(bus.rsp_vld), 64'd0);
        rd(1, 3'd1, 32'd3, 64'h55, "drop final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
